// File: rtl/ram_arbiter_if.sv
// Requester command/response channel shared by both clients of ram_arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              VALID;
  logic              READY;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_DATA;

  modport master (
    output VALID, WE, ADDR, WDATA,
    input  READY, RSP_VALID, RSP_DATA
  );

  modport slave (
    input  VALID, WE, ADDR, WDATA,
    output READY, RSP_VALID, RSP_DATA
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters, with a sequencer that fills the whole RAM with CLEAR_VALUE.
module ram_arbiter #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  ram_arbiter_if.slave      A,
  ram_arbiter_if.slave      B,
  input  logic              CLEAR_START,
  output logic              BUSY,
  output logic              CLEAR_DONE,
  output logic              RAM_RDEN,
  output logic              RAM_WREN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;          // 0 = A has priority, 1 = B
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ram_rden_q, ram_rden_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              tag1_v_q, tag1_v_d;
  logic              tag1_id_q, tag1_id_d; // 0 = A, 1 = B
  logic              tag2_v_q;
  logic              tag2_id_q;
  logic              gnt_a, gnt_b;

  // Arbitration, command registration and clear sequencing.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    ram_rden_d  = 1'b0;
    ram_wren_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag1_v_d    = 1'b0;
    tag1_id_d   = tag1_id_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    BUSY        = 1'b0;
    CLEAR_DONE  = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (CLEAR_START) begin
          state_d = ST_CLEAR;
        end else begin
          gnt_a = A.VALID && (!B.VALID || !rr_q);
          gnt_b = B.VALID && (!A.VALID ||  rr_q);
          if (gnt_a) begin
            rr_d        = 1'b1;
            ram_rden_d  = !A.WE;
            ram_wren_d  = A.WE;
            ram_addr_d  = A.ADDR;
            if (A.WE) ram_wdata_d = A.WDATA;
            tag1_v_d    = !A.WE;
            tag1_id_d   = 1'b0;
          end else if (gnt_b) begin
            rr_d        = 1'b0;
            ram_rden_d  = !B.WE;
            ram_wren_d  = B.WE;
            ram_addr_d  = B.ADDR;
            if (B.WE) ram_wdata_d = B.WDATA;
            tag1_v_d    = !B.WE;
            tag1_id_d   = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        BUSY        = 1'b1;
        ram_wren_d  = 1'b1;
        ram_addr_d  = cnt_q;
        ram_wdata_d = CLEAR_VALUE;
        cnt_d       = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          CLEAR_DONE = 1'b1;
          state_d    = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State, RAM command and read-tag pipeline registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_ARB;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      ram_rden_q  <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag1_v_q    <= 1'b0;
      tag1_id_q   <= 1'b0;
      tag2_v_q    <= 1'b0;
      tag2_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      ram_rden_q  <= ram_rden_d;
      ram_wren_q  <= ram_wren_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_v_q    <= tag1_v_d;
      tag1_id_q   <= tag1_id_d;
      tag2_v_q    <= tag1_v_q;
      tag2_id_q   <= tag1_id_q;
    end
  end

  assign A.READY     = gnt_a;
  assign B.READY     = gnt_b;
  assign A.RSP_VALID = tag2_v_q && !tag2_id_q;
  assign B.RSP_VALID = tag2_v_q &&  tag2_id_q;
  assign A.RSP_DATA  = RAM_RDATA;
  assign B.RSP_DATA  = RAM_RDATA;
  assign RAM_RDEN    = ram_rden_q;
  assign RAM_WREN    = ram_wren_q;
  assign RAM_ADDR    = ram_addr_q;
  assign RAM_WDATA   = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, directed scenarios and a randomized
// run checked against a transaction-level reference model.
module tb_ram_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        CLEAR_START;
  logic        BUSY;
  logic        CLEAR_DONE;
  logic        RAM_RDEN;
  logic        RAM_WREN;
  logic [11:0] RAM_ADDR;
  logic [15:0] RAM_WDATA;
  logic [15:0] RAM_RDATA;

  ram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) a_if ();
  ram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) b_if ();

  ram_arbiter #(.ADDR_W(12), .DATA_W(16), .CLEAR_VALUE(16'h0000)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .A           (a_if),
    .B           (b_if),
    .CLEAR_START (CLEAR_START),
    .BUSY        (BUSY),
    .CLEAR_DONE  (CLEAR_DONE),
    .RAM_RDEN    (RAM_RDEN),
    .RAM_WREN    (RAM_WREN),
    .RAM_ADDR    (RAM_ADDR),
    .RAM_WDATA   (RAM_WDATA),
    .RAM_RDATA   (RAM_RDATA)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  logic [15:0] ram_mem [4096];
  always @(posedge CLK) begin
    if (RAM_WREN) ram_mem[RAM_ADDR] <= RAM_WDATA;
    if (RAM_RDEN) RAM_RDATA <= ram_mem[RAM_ADDR];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    bit          port;
    logic [15:0] data;
    bit          known;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] ref_mem   [4096];
  bit          ref_known [4096];

  task automatic idle();
    a_if.VALID = 1'b0; a_if.WE = 1'b0; a_if.ADDR = '0; a_if.WDATA = '0;
    b_if.VALID = 1'b0; b_if.WE = 1'b0; b_if.ADDR = '0; b_if.WDATA = '0;
  endtask

  task automatic drive(input logic av, input logic awe, input logic [11:0] aa, input logic [15:0] ad,
                       input logic bv, input logic bwe, input logic [11:0] ba, input logic [15:0] bd);
    a_if.VALID = av; a_if.WE = awe; a_if.ADDR = aa; a_if.WDATA = ad;
    b_if.VALID = bv; b_if.WE = bwe; b_if.ADDR = ba; b_if.WDATA = bd;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    CLEAR_START = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 1, 12'h001, 16'h1111, 0, 0, 12'h000, 16'h0000); next_cycle();
    drive(0, 0, 12'h000, 16'h0000, 1, 0, 12'h002, 16'h0000); next_cycle();
    drive(1, 0, 12'h003, 16'h0000, 0, 0, 12'h000, 16'h0000); next_cycle();
    idle();
    #4;
    total++;
    if ({b_if.RSP_VALID, RAM_RDEN} !== 2'b11) begin
      bad++; $display("FAIL pre_reset_activity got=%b want=11", {b_if.RSP_VALID, RAM_RDEN});
    end
    #1 RST_N = 1'b0;
    #1;
    total++;
    if ({RAM_RDEN, RAM_WREN, a_if.RSP_VALID, b_if.RSP_VALID, BUSY, CLEAR_DONE} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {RAM_RDEN, RAM_WREN, a_if.RSP_VALID, b_if.RSP_VALID, BUSY, CLEAR_DONE});
    end
    total++;
    if (RAM_ADDR !== 12'h000) begin bad++; $display("FAIL reset_ram_addr got=%h want=000", RAM_ADDR); end
    total++;
    if (RAM_WDATA !== 16'h0000) begin bad++; $display("FAIL reset_ram_wdata got=%h want=0000", RAM_WDATA); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    // Both request: pointer must be back at A; A's pre-reset read must not surface.
    drive(1, 0, 12'h005, 16'h0000, 1, 0, 12'h006, 16'h0000);
    #4;
    total++;
    if ({a_if.READY, b_if.READY} !== 2'b10) begin
      bad++; $display("FAIL reset_ptr_ready got=%b want=10", {a_if.READY, b_if.READY});
    end
    total++;
    if (a_if.RSP_VALID !== 1'b0) begin bad++; $display("FAIL reset_dropped_rsp got=%b want=0", a_if.RSP_VALID); end
    next_cycle();
    idle();
    #4;
    total++;
    if ({a_if.RSP_VALID, b_if.RSP_VALID} !== 2'b00) begin
      bad++; $display("FAIL reset_rsp_gap got=%b want=00", {a_if.RSP_VALID, b_if.RSP_VALID});
    end
    next_cycle();
    #4;
    total++;
    if ({a_if.RSP_VALID, b_if.RSP_VALID} !== 2'b10) begin
      bad++; $display("FAIL reset_new_rsp got=%b want=10", {a_if.RSP_VALID, b_if.RSP_VALID});
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_addr;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, 0, 12'h010, 16'h0000, k < 4, 0, 12'h020, 16'h0000);
      #4;
      if (k < 4) begin
        total++;
        if ({a_if.READY, b_if.READY} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, {a_if.READY, b_if.READY},
                          (k % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (k >= 1 && k <= 4) begin
        exp_addr = ((k - 1) % 2 == 0) ? 12'h010 : 12'h020;
        total++;
        if (RAM_RDEN !== 1'b1 || RAM_WREN !== 1'b0 || RAM_ADDR !== exp_addr) begin
          bad++; $display("FAIL rr_ram_cmd[%0d] got=rden%b wren%b addr%h want=rden1 wren0 addr%h",
                          k, RAM_RDEN, RAM_WREN, RAM_ADDR, exp_addr);
        end
      end
      total++;
      if (k >= 2) begin
        if ({a_if.RSP_VALID, b_if.RSP_VALID} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_rsp[%0d] got=%b want=%b", k, {a_if.RSP_VALID, b_if.RSP_VALID},
                          (k % 2 == 0) ? 2'b10 : 2'b01);
        end
      end else if ({a_if.RSP_VALID, b_if.RSP_VALID} !== 2'b00) begin
        bad++; $display("FAIL rr_rsp[%0d] got=%b want=00", k, {a_if.RSP_VALID, b_if.RSP_VALID});
      end
      next_cycle();
    end
  endtask

  task automatic test_write_readback();
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      drive(1, 1, 12'hFFF, 16'hBEEF, 0, 0, 12'h000, 16'h0000);
      else if (k == 1) drive(0, 0, 12'h000, 16'h0000, 1, 0, 12'hFFF, 16'h0000);
      else             idle();
      #4;
      if (k == 0) begin
        total++;
        if (a_if.READY !== 1'b1) begin bad++; $display("FAIL wr_a_ready got=%b want=1", a_if.READY); end
      end
      if (k == 1) begin
        total++;
        if (b_if.READY !== 1'b1) begin bad++; $display("FAIL rd_b_ready got=%b want=1", b_if.READY); end
      end
      total++;
      if (a_if.RSP_VALID !== 1'b0) begin bad++; $display("FAIL wr_no_a_rsp[%0d] got=%b want=0", k, a_if.RSP_VALID); end
      total++;
      if (b_if.RSP_VALID !== (k == 3)) begin
        bad++; $display("FAIL rb_b_rsp_valid[%0d] got=%b want=%b", k, b_if.RSP_VALID, k == 3);
      end
      if (k == 3) begin
        total++;
        if (b_if.RSP_DATA !== 16'hBEEF) begin bad++; $display("FAIL rb_b_rsp_data got=%h want=beef", b_if.RSP_DATA); end
      end
      next_cycle();
    end
    ref_mem[12'hFFF] = 16'hBEEF;
    ref_known[12'hFFF] = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(0, 0, 12'h000, 16'h0000, 1, 0, 12'($urandom_range(0, 4095)), 16'h0000);
      else       idle();
      #4;
      if (k < 3) begin
        total++;
        if ({a_if.READY, b_if.READY} !== 2'b01) begin
          bad++; $display("FAIL single_ready[%0d] got=%b want=01", k, {a_if.READY, b_if.READY});
        end
      end
      if (RAM_RDEN === 1'b1 && RAM_WREN === 1'b1) ok = 1'b0;
      next_cycle();
    end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL single_rden_wren_excl got=%b want=1", ok); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cnt;
    bit seq_ok;
    bit done_ok;
    drive(1, 1, 12'h123, 16'h5A5A, 0, 0, 12'h000, 16'h0000);
    #4;
    total++;
    if (a_if.READY !== 1'b1) begin bad++; $display("FAIL clr_preload_ready got=%b want=1", a_if.READY); end
    next_cycle();
    idle(); next_cycle(); next_cycle();
    drive(1, 0, 12'h123, 16'h0000, 0, 0, 12'h000, 16'h0000);
    CLEAR_START = 1'b1;
    #4;
    total++;
    if ({a_if.READY, b_if.READY, BUSY} !== 3'b000) begin
      bad++; $display("FAIL clr_start_cycle got=%b want=000", {a_if.READY, b_if.READY, BUSY});
    end
    next_cycle();
    CLEAR_START = 1'b0;
    busy_cnt = 0; done_cnt = 0; seq_ok = 1'b1; done_ok = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      CLEAR_START = (k == 100);
      #4;
      if (BUSY !== 1'b1) break;
      if (a_if.READY !== 1'b0 || b_if.READY !== 1'b0) seq_ok = 1'b0;
      if (busy_cnt > 0 && (RAM_WREN !== 1'b1 || RAM_RDEN !== 1'b0 ||
                           RAM_ADDR !== 12'(busy_cnt - 1) || RAM_WDATA !== 16'h0000)) seq_ok = 1'b0;
      if (CLEAR_DONE === 1'b1) begin
        done_cnt++;
        if (busy_cnt != 4095) done_ok = 1'b0;
      end
      busy_cnt++;
      next_cycle();
    end
    CLEAR_START = 1'b0;
    total++;
    if (busy_cnt != 4096) begin bad++; $display("FAIL clr_busy_cycles got=%0d want=4096", busy_cnt); end
    total++;
    if (done_cnt != 1 || !done_ok) begin
      bad++; $display("FAIL clr_done_pulse got=count%0d at_last%0d want=count1 at_last1", done_cnt, done_ok);
    end
    total++;
    if (!seq_ok) begin bad++; $display("FAIL clr_write_seq got=0 want=1"); end
    total++;
    if ({a_if.READY, RAM_WREN, CLEAR_DONE} !== 3'b110 || RAM_ADDR !== 12'hFFF) begin
      bad++; $display("FAIL clr_exit_cycle got=rdy%b wren%b done%b addr%h want=rdy1 wren1 done0 addrfff",
                      a_if.READY, RAM_WREN, CLEAR_DONE, RAM_ADDR);
    end
    next_cycle();
    idle();
    #4;
    total++;
    if (RAM_RDEN !== 1'b1 || RAM_ADDR !== 12'h123) begin
      bad++; $display("FAIL clr_readback_cmd got=rden%b addr%h want=rden1 addr123", RAM_RDEN, RAM_ADDR);
    end
    next_cycle();
    #4;
    total++;
    if (a_if.RSP_VALID !== 1'b1 || a_if.RSP_DATA !== 16'h0000) begin
      bad++; $display("FAIL clr_readback got=v%b d%h want=v1 d0000", a_if.RSP_VALID, a_if.RSP_DATA);
    end
    next_cycle();
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 16'h0000;
      ref_known[i] = 1'b1;
    end
  endtask

  task automatic test_random();
    rsp_t        q[$];
    rsp_t        r;
    bit          rr;
    int          cyc;
    logic        av, bv, awe, bwe;
    logic [11:0] aa, ba;
    logic [15:0] ad, bd;
    bit          ga, gb, ea, eb, ek;
    logic [15:0] ed;
    do_reset();
    rr = 1'b0;
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      av  = (n < 390) && ($urandom_range(0, 3) != 0);
      bv  = (n < 390) && ($urandom_range(0, 3) != 0);
      awe = ($urandom_range(0, 2) == 0);
      bwe = ($urandom_range(0, 2) == 0);
      aa  = 12'h0F0 | 12'($urandom_range(0, 15));
      ba  = 12'h0F0 | 12'($urandom_range(0, 15));
      ad  = 16'($urandom);
      bd  = 16'($urandom);
      drive(av, awe, aa, ad, bv, bwe, ba, bd);
      #4;
      ga = av && (!bv || !rr);
      gb = bv && (!av ||  rr);
      total++;
      if ({a_if.READY, b_if.READY} !== {ga, gb}) begin
        bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b%b", n, {a_if.READY, b_if.READY}, ga, gb);
      end
      ea = 1'b0; eb = 1'b0; ek = 1'b0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        ea = (r.port == 1'b0);
        eb = (r.port == 1'b1);
        ek = r.known;
        ed = r.data;
      end
      total++;
      if ({a_if.RSP_VALID, b_if.RSP_VALID} !== {ea, eb}) begin
        bad++; $display("FAIL rnd_rsp_valid[%0d] got=%b want=%b%b", n, {a_if.RSP_VALID, b_if.RSP_VALID}, ea, eb);
      end
      if (ek && ea) begin
        total++;
        if (a_if.RSP_DATA !== ed) begin bad++; $display("FAIL rnd_a_data[%0d] got=%h want=%h", n, a_if.RSP_DATA, ed); end
      end
      if (ek && eb) begin
        total++;
        if (b_if.RSP_DATA !== ed) begin bad++; $display("FAIL rnd_b_data[%0d] got=%h want=%h", n, b_if.RSP_DATA, ed); end
      end
      total++;
      if (RAM_RDEN === 1'b1 && RAM_WREN === 1'b1) begin
        bad++; $display("FAIL rnd_rden_wren[%0d] got=11 want=not both", n);
      end
      if (ga) begin
        if (awe) begin ref_mem[aa] = ad; ref_known[aa] = 1'b1; end
        else q.push_back('{cyc + 2, 1'b0, ref_mem[aa], ref_known[aa]});
        rr = 1'b1;
      end else if (gb) begin
        if (bwe) begin ref_mem[ba] = bd; ref_known[ba] = 1'b1; end
        else q.push_back('{cyc + 2, 1'b1, ref_mem[ba], ref_known[ba]});
        rr = 1'b0;
      end
      next_cycle();
      cyc++;
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rnd_missing_rsp got=%0d want=0", q.size()); end
  endtask

  task automatic test_reset_mid_clear();
    bit quiet;
    idle();
    CLEAR_START = 1'b1;
    #4;
    next_cycle();
    CLEAR_START = 1'b0;
    repeat (12'h400) next_cycle();
    #4;
    total++;
    if (BUSY !== 1'b1 || RAM_ADDR !== 12'h3FF) begin
      bad++; $display("FAIL mclr_before got=busy%b addr%h want=busy1 addr3ff", BUSY, RAM_ADDR);
    end
    #1 RST_N = 1'b0;
    #1;
    total++;
    if ({BUSY, RAM_WREN, CLEAR_DONE} !== 3'b000) begin
      bad++; $display("FAIL mclr_reset got=%b want=000", {BUSY, RAM_WREN, CLEAR_DONE});
    end
    next_cycle();
    RST_N = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive(1, 0, 12'h010, 16'h0000, 0, 0, 12'h000, 16'h0000);
      else        idle();
      #4;
      if (k == 0) begin
        total++;
        if (a_if.READY !== 1'b1) begin bad++; $display("FAIL mclr_arb_ready got=%b want=1", a_if.READY); end
      end
      if (BUSY !== 1'b0 || CLEAR_DONE !== 1'b0 || RAM_WREN !== 1'b0) quiet = 1'b0;
      next_cycle();
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL mclr_after_quiet got=0 want=1"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    CLEAR_START = 1'b0;
    idle();
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 16'h0000;
      ref_known[i] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_write_readback();
    test_single();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
